// File: rtl/ram_8x16.sv
// ram_8x16 -- eight-word register-file RAM, the base of the memory hierarchy.
//
// Ports:
//   clk      system clock; writes occur on its rising edge
//   reset    asynchronous, active-high; clears all words while asserted
//   in       write data (DATA_WIDTH)
//   address  3-bit word select shared by read and write
//   load     write enable, sampled on the rising edge of clk
//   out      read data: word[address], combinational (DATA_WIDTH)
//
// Build option: define RAM_8X16_BYPASS_EN for write-through bypass
// (out = in while load=1, before the writing edge).
//
// Structure: 1-to-8 load demux -> 8 clearable load-enable registers ->
// 8-to-1 output mux.  Decode compares against known values only, so an X/Z
// on load or address selects no word and unselected words are never touched.

module ram_8x16_demux (
  input  logic       load,
  input  logic [2:0] address,
  output logic [7:0] sel
);
  always_comb begin
    sel = '0;
    if (load == 1'b1) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (address == 3'(i)) sel[i] = 1'b1;
      end
    end
  end
endmodule

module ram_8x16_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] word_q;

  always_comb begin
    word_d = word_q;
    if (ld == 1'b1) word_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) word_q <= '0;
    else       word_q <= word_d;
  end

  assign q = word_q;
endmodule

module ram_8x16_mux #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [7:0][DATA_WIDTH-1:0] words,
  input  logic [2:0]                 address,
  output logic [DATA_WIDTH-1:0]      data
);
  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (address == 3'(i)) data = words[i];
    end
  end
endmodule

module ram_8x16 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [2:0]            address,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] out
);
  logic [7:0]                 sel;
  logic [7:0][DATA_WIDTH-1:0] words;
  logic [DATA_WIDTH-1:0]      rd_data;

  ram_8x16_demux u_demux (
    .load    (load),
    .address (address),
    .sel     (sel)
  );

  for (genvar g = 0; g < 8; g++) begin : g_word
    ram_8x16_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .ld    (sel[g]),
      .d     (in),
      .q     (words[g])
    );
  end

  ram_8x16_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .words   (words),
    .address (address),
    .data    (rd_data)
  );

  always_comb begin
    out = rd_data;
`ifdef RAM_8X16_BYPASS_EN
    if (load == 1'b1) out = in;
`else
`endif
    // Storage is already cleared under reset; the explicit gate also
    // overrides the bypass path.
    if (reset) out = '0;
  end
endmodule

// File: tb/tb_ram_8x16.sv
// tb_ram_8x16 -- self-checking bench for ram_8x16.
// Stimulus pushes expected values into a queue and fires an event; a
// separate monitor pops and compares against the DUT output.

module tb_ram_8x16;
  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic [2:0]  address;
  logic        load;
  logic [15:0] out;

  ram_8x16 #(.DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .address (address),
    .load    (load),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  string       name_q [$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  event        sample_ev;

`ifdef RAM_8X16_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Monitor: compares every queued expectation when the output is presented.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        automatic logic [15:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        total_cnt++;
        if (out === e) pass_cnt++;
        else $display("FAIL %s: out=%h expected=%h", n, out, e);
      end
    end
  end

  task automatic expect_out(input string n, input logic [15:0] e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    -> sample_ev;
    #1;
  endtask

  // Write with a pre-edge check of the old contents (or bypassed data).
  task automatic write_word(input logic [2:0] a, input logic [15:0] d,
                            input logic [15:0] old_val);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    expect_out($sformatf("pre_edge_a%0d", a), BYPASS ? d : old_val);
    @(posedge clk);
    #1;
    load = 1'b0;
    expect_out($sformatf("post_write_a%0d", a), d);
  endtask

  task automatic sweep(input string tag, input logic [15:0] e [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      address = 3'(i);
      expect_out($sformatf("%s_a%0d", tag, i), e[i]);
    end
  endtask

  logic [15:0] zeros [8] = '{default: 16'h0000};
  logic [15:0] iso   [8] = '{16'h0001, 16'h0003, 16'h0000, 16'h0000,
                             16'h001F, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    reset = 1'b0; load = 1'b0; address = 3'd0; in = 16'h0000;
    // Reset pulse with no clock edge in between (first posedge at t=5).
    #1 reset = 1'b1;
    expect_out("reset_immediate", 16'h0000);
    reset = 1'b0;
    sweep("reset_sweep", zeros);

    write_word(3'd0, 16'h0001, 16'h0000);
    write_word(3'd1, 16'h0003, 16'h0000);
    @(negedge clk); address = 3'd0;
    expect_out("reselect_a0", 16'h0001);

    // load low: nothing written
    @(negedge clk); address = 3'd2; in = 16'h0007; load = 1'b0;
    @(posedge clk);
    expect_out("load_low_a2", 16'h0000);
    @(negedge clk); address = 3'd3; in = 16'h000F;
    @(posedge clk);
    expect_out("load_low_a3", 16'h0000);

    write_word(3'd4, 16'h001F, 16'h0000);
    sweep("isolation", iso);

    write_word(3'd7, 16'hFFFF, 16'h0000);
    write_word(3'd7, 16'hA5A5, 16'hFFFF);
    address = 3'd0;  // mid-cycle, no edge
    expect_out("async_read_a0", 16'h0001);

    // Reset held across a write edge
    @(negedge clk);
    address = 3'd5; in = 16'h1234; load = 1'b1; reset = 1'b1;
    expect_out("reset_load_pre", 16'h0000);
    @(posedge clk);
    expect_out("reset_load_post", 16'h0000);
    @(negedge clk);
    load = 1'b0; reset = 1'b0;
    sweep("post_reset", zeros);

    // First write after deassertion works; bypass shows data pre-edge.
    write_word(3'd6, 16'h1234, 16'h0000);
    @(negedge clk); address = 3'd5;
    expect_out("a5_still_zero", 16'h0000);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL monitor_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
